// File: rtl/digit_serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor.
// One DIGIT_W-bit digit is accepted per valid beat, least significant digit
// first. WORD_DIGITS digits form a word, and the carry chain restarts at each
// word boundary. The mode (add or subtract) is latched on the first digit of
// each word. All outputs are registered, with exactly one cycle of latency.
module digit_serial_add_sub #(
    parameter int unsigned DIGIT_W     = 1,
    parameter int unsigned WORD_DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               first_in,
    input  logic               sub_in,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               valid_out,
    output logic [DIGIT_W-1:0] sum,
    output logic               last_out,
    output logic               carry_out,
    output logic               overflow,
    output logic               err
);

    localparam int unsigned      CNT_W    = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_mode;

    logic               w_start;
    logic               w_early;
    logic               w_mode;
    logic               w_cin;
    logic               w_last;
    logic [CNT_W-1:0]   w_idx;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DIGIT_W-1:0] w_bb;
    logic [DIGIT_W-1:0] w_sum;
    logic               w_c_msb;   // carry into the digit MSB, c_{DIGIT_W-1}
    logic               w_c_top;   // carry out of the digit MSB, c_DIGIT_W

    // Word framing: decide whether this digit starts a word, is the word's last
    // digit, or aborts a partial word.
    always_comb begin
        w_start   = (r_cnt == '0) || first_in;
        w_early   = first_in && (r_cnt != '0);
        w_mode    = w_start ? sub_in : r_mode;
        w_cin     = w_start ? sub_in : r_carry;
        // A start digit is always digit 0, even when it aborts a partial word.
        w_idx     = w_start ? '0 : r_cnt;
        w_last    = (w_idx == LAST_IDX);
        w_cnt_nxt = w_last ? '0 : (w_idx + CNT_W'(1));
    end

    // Ripple of DIGIT_W full adders on a and the conditionally inverted b.
    always_comb begin
        logic v_c;
        w_bb    = b ^ {DIGIT_W{w_mode}};
        w_sum   = '0;
        v_c     = w_cin;
        w_c_msb = w_cin;
        for (int unsigned i = 0; i < DIGIT_W; i++) begin
            w_c_msb  = v_c;
            w_sum[i] = a[i] ^ w_bb[i] ^ v_c;
            v_c      = (a[i] & w_bb[i]) | ((a[i] ^ w_bb[i]) & v_c);
        end
        w_c_top = v_c;
    end

    // Word state: the counter, carry and mode advance only on accepted digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_mode  <= 1'b0;
        end else if (valid_in) begin
            r_cnt   <= w_cnt_nxt;
            r_carry <= w_last ? 1'b0 : w_c_top;
            r_mode  <= w_mode;
        end
    end

    // Registered outputs; the flags are forced to zero on bubbles and non-last digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            sum       <= '0;
            last_out  <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid_out <= valid_in;
            sum       <= valid_in ? w_sum : '0;
            last_out  <= valid_in & w_last;
            carry_out <= valid_in & w_last & w_c_top;
            overflow  <= valid_in & w_last & (w_c_top ^ w_c_msb);
            err       <= valid_in & w_early;
        end
    end

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Directed, table-driven bench covering three parameterisations of digit_serial_add_sub.
module tb_digit_serial_add_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DIGIT_W=1, WORD_DIGITS=8
    logic       v1 = 0, f1 = 0, s1 = 0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       ov1, last1, c1, vf1, e1;
    logic [0:0] sum1;
    // DIGIT_W=4, WORD_DIGITS=2
    logic       v4 = 0, f4 = 0, s4 = 0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ov4, last4, c4, vf4, e4;
    logic [3:0] sum4;
    // DIGIT_W=8, WORD_DIGITS=1
    logic       v8 = 0, f8 = 0, s8 = 0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ov8, last8, c8, vf8, e8;
    logic [7:0] sum8;

    digit_serial_add_sub #(.DIGIT_W(1), .WORD_DIGITS(8)) u1 (
        .clk(clk), .rst(rst), .valid_in(v1), .first_in(f1), .sub_in(s1),
        .a(a1), .b(b1), .valid_out(ov1), .sum(sum1), .last_out(last1),
        .carry_out(c1), .overflow(vf1), .err(e1));

    digit_serial_add_sub #(.DIGIT_W(4), .WORD_DIGITS(2)) u4 (
        .clk(clk), .rst(rst), .valid_in(v4), .first_in(f4), .sub_in(s4),
        .a(a4), .b(b4), .valid_out(ov4), .sum(sum4), .last_out(last4),
        .carry_out(c4), .overflow(vf4), .err(e4));

    digit_serial_add_sub #(.DIGIT_W(8), .WORD_DIGITS(1)) u8 (
        .clk(clk), .rst(rst), .valid_in(v8), .first_in(f8), .sub_in(s8),
        .a(a8), .b(b8), .valid_out(ov8), .sum(sum8), .last_out(last8),
        .carry_out(c8), .overflow(vf8), .err(e8));

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       c;
        logic       v;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic beat1(input logic v, input logic f, input logic s, input logic a, input logic b);
        v1 = v; f1 = f; s1 = s; a1 = a; b1 = b;
        @(posedge clk); #1;
    endtask

    task automatic beat4(input logic v, input logic f, input logic s, input logic [3:0] a, input logic [3:0] b);
        v4 = v; f4 = f; s4 = s; a4 = a; b4 = b;
        @(posedge clk); #1;
    endtask

    task automatic beat8(input logic v, input logic f, input logic s, input logic [7:0] a, input logic [7:0] b);
        v8 = v; f8 = f; s8 = s; a8 = a; b8 = b;
        @(posedge clk); #1;
    endtask

    // Eight back-to-back bit-serial beats; sub_in is inverted after digit 0
    // so that any late sampling of the mode would show up.
    task automatic word1(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic first0, input logic err0,
                         input logic [7:0] es, input logic ec, input logic ev);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            beat1(1'b1, (i == 0) ? first0 : 1'b0, (i == 0) ? sub : ~sub, a[i], b[i]);
            chk({tag, " valid"}, 32'(ov1), 32'd1);
            chk({tag, " last"}, 32'(last1), (i == 7) ? 32'd1 : 32'd0);
            chk({tag, " err"}, 32'(e1), (i == 0) ? 32'(err0) : 32'd0);
            s[i] = sum1[0];
        end
        chk({tag, " sum"}, 32'(s), 32'(es));
        chk({tag, " carry"}, 32'(c1), 32'(ec));
        chk({tag, " ovf"}, 32'(vf1), 32'(ev));
        v1 = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"add5A3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{"sub1020", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[2] = '{"addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{"add7F01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{"sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{"sub0000", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{"addC8C8", 8'hC8, 8'hC8, 1'b0, 8'h90, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid1", 32'(ov1), 0);
        chk("rst last1", 32'(last1), 0);
        chk("rst err1", 32'(e1), 0);
        chk("rst valid4", 32'(ov4), 0);
        chk("rst sum4", 32'(sum4), 0);
        chk("rst valid8", 32'(ov8), 0);
        chk("rst flags8", {29'd0, c8, vf8, last8}, 0);
        rst = 1'b0;

        // Back-to-back words on the bit-serial instance
        for (int i = 0; i < 7; i++)
            word1(tbl[i].tag, tbl[i].a, tbl[i].b, tbl[i].sub, 1'b1, 1'b0,
                  tbl[i].sum, tbl[i].c, tbl[i].v);

        // Nibble-serial 0x7F+0x01 with a three-cycle bubble between digits
        beat4(1'b1, 1'b1, 1'b0, 4'hF, 4'h1);
        chk("bub d0 valid", 32'(ov4), 1);
        chk("bub d0 sum", 32'(sum4), 32'h0);
        chk("bub d0 last", 32'(last4), 0);
        for (int i = 0; i < 3; i++) begin
            beat4(1'b0, 1'b1, 1'b1, 4'hA, 4'h5);
            chk("bub idle valid", 32'(ov4), 0);
            chk("bub idle flags", {28'd0, e4, c4, vf4, last4}, 0);
        end
        beat4(1'b1, 1'b0, 1'b1, 4'h7, 4'h0);
        chk("bub d1 valid", 32'(ov4), 1);
        chk("bub d1 sum", 32'(sum4), 32'h8);
        chk("bub d1 last", 32'(last4), 1);
        chk("bub d1 carry", 32'(c4), 0);
        chk("bub d1 ovf", 32'(vf4), 1);
        chk("bub d1 err", 32'(e4), 0);
        beat4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("bub after valid", 32'(ov4), 0);

        // Early first_in aborts a partial word whose carry is set
        for (int i = 0; i < 3; i++) begin
            beat1(1'b1, (i == 0), 1'b0, 1'b1, 1'b1);
            chk("abort pre err", 32'(e1), 0);
            chk("abort pre last", 32'(last1), 0);
        end
        word1("abort new", 8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);

        // Asynchronous reset mid-word, then a word starting with first_in=0
        for (int i = 0; i < 2; i++)
            beat1(1'b1, (i == 0), 1'b0, 1'b1, 1'b1);
        chk("arst pre valid", 32'(ov1), 1);
        chk("arst pre sum", 32'(sum1), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst valid", 32'(ov1), 0);
        chk("arst sum", 32'(sum1), 0);
        v1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        word1("post rst", 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);

        // Single-digit words
        beat8(1'b1, 1'b1, 1'b1, 8'h80, 8'h01);
        chk("w1 sub valid", 32'(ov8), 1);
        chk("w1 sub sum", 32'(sum8), 32'h7F);
        chk("w1 sub last", 32'(last8), 1);
        chk("w1 sub carry", 32'(c8), 1);
        chk("w1 sub ovf", 32'(vf8), 1);
        chk("w1 sub err", 32'(e8), 0);
        beat8(1'b1, 1'b0, 1'b0, 8'h01, 8'h01);
        chk("w1 add sum", 32'(sum8), 32'h02);
        chk("w1 add last", 32'(last8), 1);
        chk("w1 add flags", {29'd0, e8, c8, vf8}, 0);
        beat8(1'b1, 1'b1, 1'b0, 8'hF0, 8'h20);
        chk("w1 add2 sum", 32'(sum8), 32'h10);
        chk("w1 add2 carry", 32'(c8), 1);
        chk("w1 add2 err", 32'(e8), 0);
        beat8(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("w1 idle", {27'd0, ov8, e8, c8, vf8, last8}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_serial_add_sub.md
Name: digit_serial_add_sub

Overview:
- Parametrised digit-serial two's-complement adder/subtractor; generalises the 1-bit serial adder.
- Processes one DIGIT_W-bit digit per accepted beat, LSB digit first; WORD_DIGITS digits form one word.
- Carry chain restarts automatically at word boundaries; add/sub mode is selected per word.
- Per-word carry and signed-overflow flags on the last digit; valid qualifier tolerates input bubbles; sits between serial bit/nibble streams in the datapath.

Parameters:
- DIGIT_W, 1, bits per digit (>=1).
- WORD_DIGITS, 8, digits per word (>=1); word width = DIGIT_W*WORD_DIGITS.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset; clears all state
- valid_in  input  1  a/b/first_in/sub_in valid this cycle
- first_in  input  1  current digit is first (least significant) digit of a word
- sub_in  input  1  mode for the word, sampled on its first digit; 1 = a-b, 0 = a+b
- a  input  DIGIT_W  operand A digit
- b  input  DIGIT_W  operand B digit
- valid_out  output  1  sum digit valid
- sum  output  DIGIT_W  result digit
- last_out  output  1  sum is last digit of the word
- carry_out  output  1  carry out of word MSB (sub: 1 = no borrow); valid only with last_out
- overflow  output  1  signed overflow of the word; valid only with last_out
- err  output  1  one-cycle pulse: word aborted by early first_in

Behaviour:
- Reset (async assert): digit counter=0, carry=0, mode=0, all outputs 0. Synchronous release; the first accepted digit after reset starts a word.
- Accepted beat: valid_in=1. With valid_in=0, counter, carry and mode hold, and valid_out=0 next cycle; last_out, carry_out, overflow and err are also 0.
- Word start: the digit is a start digit if counter==0 or first_in=1.
  - On a start digit, mode is taken from sub_in and carry-in = sub_in.
  - Otherwise carry-in = stored carry and mode = stored mode.
- Operand: bb = b XOR {DIGIT_W{mode}}.
- Digit sum: ripple of DIGIT_W full adders built only from ^ & | ~.
  - s_i = a_i ^ bb_i ^ c_i.
  - c_{i+1} = (a_i & bb_i) | ((a_i ^ bb_i) & c_i).
- Latency: exactly 1 cycle. All outputs are registered, and sum, valid_out, last_out and the flags update together.
- Counter: increments on each accepted digit. On the accepted digit where counter==WORD_DIGITS-1:
  - last_out=1 next cycle.
  - carry_out = c_DIGIT_W.
  - overflow = c_DIGIT_W ^ c_{DIGIT_W-1}.
  - Counter wraps to 0 and stored carry is cleared.
- Last digits and WORD_DIGITS=1: when the last digit is also a start digit (WORD_DIGITS=1), every digit is a complete word and last_out=1 on every valid_out.
- Early first_in: first_in=1 while counter!=0 aborts the partial word.
  - No last_out is emitted for the aborted word.
  - err=1 for one cycle, aligned with that digit's valid_out.
  - The digit is processed as digit 0 of a new word, counter=1 afterwards.
- first_in=1 at counter==0 is normal and gives no err. first_in=0 at counter==0 still starts a word.
- Reset mid-word: the partial word is discarded; no output pulses.
- Carry/overflow/err/last_out are 0 whenever valid_out=0 or last_out=0 (err excepted as defined).

Test Plan:
- DIGIT_W=1, WORD_DIGITS=8, add 0x5A+0x3C, LSB first, 8 back-to-back beats -> sum bits form 0x96; last_out on 8th output; carry_out=0, overflow=1.
- Same config, sub 0x10-0x20 -> result 0xF0, carry_out=0 (borrow), overflow=0. Then add 0xFF+0x01 immediately after -> 0x00, carry_out=1, overflow=0, and the carry from the previous word is not leaked in.
- DIGIT_W=4, WORD_DIGITS=2, add 0x7F+0x01 with valid_in low for 3 cycles between digits -> sums 0x0 then 0x8, no outputs during bubbles, overflow=1, carry_out=0.
- DIGIT_W=1, WORD_DIGITS=8: 3 digits of a word, then first_in=1 with a new word 0x01+0x01 -> err pulse on 4th output, no last_out for the aborted word; new word result 0x02, last_out after 8 more digits.
- Assert rst asynchronously (off clock edge) mid-word -> outputs 0 immediately. Then word 0x03+0x05 -> 0x08, carry_out=0.
- DIGIT_W=8, WORD_DIGITS=1, sub 0x80-0x01 -> sum 0x7F, last_out=1, overflow=1, carry_out=1 on a single beat.
